// File: rtl/opb_register_ppc2simulink.sv
// ---------------------------------------------------------------------------------------------
// opb_register_ppc2simulink
//
// OPB slave register that carries a 32-bit word from the PowerPC to user fabric. Software
// writes a shadow word (with byte enables) and the shadow is committed to user_data_out,
// either on every DATA write (C_AUTO_COMMIT=1) or only through a CTRL write with bit 31 set.
// Each commit raises user_data_valid for one cycle and bumps a software-visible counter.
//
// Register map (OPB_ABus[28:29]):
//   0x0 DATA  : RW shadow word
//   0x4 CTRL  : write DBus[0]=1 commits; read {31'b0, pending}
//   0x8 COUNT : RO commit counter
//   0xC       : reads 0, writes ignored
//
// Ports:
//   OPB_Clk, OPB_Rst          : clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW      : OPB address, byte enables, write data, read-not-write
//   OPB_select, OPB_seqAddr   : transfer request, sequential hint (ignored)
//   Sl_DBus, Sl_xferAck       : read data (zero outside a read ack), transfer acknowledge
//   Sl_errAck/retry/toutSup   : tied low
//   user_data_out             : committed word, OPB_DBus[0] maps to bit 31
//   user_data_valid           : one-cycle strobe on each commit
// ---------------------------------------------------------------------------------------------
module opb_register_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR    = 32'h0108B500,
    parameter logic [31:0] C_HIGHADDR    = 32'h0108B5FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter              C_FAMILY      = "virtex6",
    parameter bit          C_AUTO_COMMIT = 1'b1,
    parameter logic [31:0] C_RESET_VALUE = 32'h00000000
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    output logic                        Sl_xferAck,
    output logic [31:0]                 user_data_out,
    output logic                        user_data_valid
);

    typedef enum logic [1:0] {StIdle, StAck, StWait} state_e;

    localparam logic [1:0] OffData  = 2'd0;
    localparam logic [1:0] OffCtrl  = 2'd1;
    localparam logic [1:0] OffCount = 2'd2;

    state_e      r_state;
    logic [31:0] r_shadow;
    logic [31:0] r_user_data;
    logic [31:0] r_cnt;
    logic [31:0] r_sl_dbus;
    logic        r_xfer_ack;
    logic        r_valid;

    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [1:0]  w_offset;
    logic        w_hit;
    logic        w_wr;
    logic        w_commit;
    logic [31:0] w_shadow_new;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Big-endian OPB bit 0 lands on bit 31 / byte-enable 0 on byte 3 via positional assignment.
    assign w_wdata  = OPB_DBus;
    assign w_be     = OPB_BE;
    assign w_offset = {OPB_ABus[28], OPB_ABus[29]};
    assign w_hit    = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign w_wr     = w_hit && !OPB_RNW && (r_state == StIdle);

    // The commit must carry the bytes being written in the same cycle, so it uses the
    // merged value rather than the registered shadow.
    always_comb begin
        w_shadow_new = r_shadow;
        if (w_wr && (w_offset == OffData)) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    w_shadow_new[8*i +: 8] = w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign w_commit = w_wr && (((w_offset == OffData) && C_AUTO_COMMIT) ||
                               ((w_offset == OffCtrl) && w_wdata[31]));

    always_comb begin
        w_rdata = 32'h0;
        case (w_offset)
            OffData:  w_rdata = r_shadow;
            OffCtrl:  w_rdata = {31'b0, (r_shadow != r_user_data)};
            OffCount: w_rdata = r_cnt;
            default:  w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_state     <= StIdle;
            r_shadow    <= C_RESET_VALUE;
            r_user_data <= C_RESET_VALUE;
            r_cnt       <= 32'h0;
            r_sl_dbus   <= 32'h0;
            r_xfer_ack  <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_xfer_ack <= 1'b0;
            r_sl_dbus  <= 32'h0;
            r_valid    <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_hit) begin
                        r_state    <= StAck;
                        r_xfer_ack <= 1'b1;
                        if (OPB_RNW) begin
                            r_sl_dbus <= w_rdata;
                        end else begin
                            r_shadow <= w_shadow_new;
                            if (w_commit) begin
                                r_user_data <= w_shadow_new;
                                r_valid     <= 1'b1;
                                r_cnt       <= r_cnt + 32'd1;
                            end
                        end
                    end
                end
                StAck: r_state <= StWait;
                // Hold off until the master drops select so one select yields one ack.
                StWait: begin
                    if (!OPB_select) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign Sl_DBus         = r_sl_dbus;
    assign Sl_xferAck      = r_xfer_ack;
    assign Sl_errAck       = 1'b0;
    assign Sl_retry        = 1'b0;
    assign Sl_toutSup      = 1'b0;
    assign user_data_out   = r_user_data;
    assign user_data_valid = r_valid;

    assign w_unused = ^{OPB_seqAddr, C_FAMILY};

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
module tb_opb_register_ppc2simulink;

    localparam logic [31:0] Base = 32'h0108B500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:31] abus = '0;
    logic [0:3]  be = '0;
    logic [0:31] dbus = '0;
    logic        rnw = 1'b0;
    logic        sel_a = 1'b0;
    logic        sel_m = 1'b0;
    logic        seq = 1'b0;

    logic [0:31] a_dbus, m_dbus;
    logic        a_err, a_retry, a_tout, a_ack, a_valid;
    logic        m_err, m_retry, m_tout, m_ack, m_valid;
    logic [31:0] a_udo, m_udo;

    int checks = 0;
    int failures = 0;

    logic [31:0] rd, idb;
    int          ac, na, nv;

    always #5 clk = ~clk;

    opb_register_ppc2simulink #(.C_AUTO_COMMIT(1'b1)) u_auto (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel_a), .OPB_seqAddr(seq), .Sl_DBus(a_dbus),
        .Sl_errAck(a_err), .Sl_retry(a_retry), .Sl_toutSup(a_tout), .Sl_xferAck(a_ack),
        .user_data_out(a_udo), .user_data_valid(a_valid)
    );

    opb_register_ppc2simulink #(.C_AUTO_COMMIT(1'b0)) u_man (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel_m), .OPB_seqAddr(seq), .Sl_DBus(m_dbus),
        .Sl_errAck(m_err), .Sl_retry(m_retry), .Sl_toutSup(m_tout), .Sl_xferAck(m_ack),
        .user_data_out(m_udo), .user_data_valid(m_valid)
    );

    // One OPB transfer: select held for 'hold' cycles, then 3 idle cycles. Reports the cycle
    // of the first ack (1 = cycle after select), ack and valid counts, read data captured
    // on the ack, and the OR of Sl_DBus over all non-ack cycles.
    task automatic xfer(input bit man, input logic [31:0] addr, input logic [3:0] b,
                        input logic [31:0] data, input logic r, input int hold,
                        output logic [31:0] rdata, output int ack_cyc, output int n_ack,
                        output int n_valid, output logic [31:0] idle_dbus);
        logic        a, v;
        logic [31:0] db;
        abus = addr; be = b; dbus = data; rnw = r;
        if (man) sel_m = 1'b1; else sel_a = 1'b1;
        rdata = '0; ack_cyc = -1; n_ack = 0; n_valid = 0; idle_dbus = '0;
        for (int c = 1; c <= hold + 3; c++) begin
            @(posedge clk); #1;
            a  = man ? m_ack : a_ack;
            v  = man ? m_valid : a_valid;
            db = man ? m_dbus : a_dbus;
            if (a) begin
                n_ack++;
                if (ack_cyc < 0) ack_cyc = c;
                rdata = db;
            end else begin
                idle_dbus = idle_dbus | db;
            end
            if (v) n_valid++;
            if (c == hold) begin
                sel_a = 1'b0; sel_m = 1'b0;
            end
        end
        abus = '0; be = '0; dbus = '0; rnw = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_udo !== 32'h0) begin failures++; $display("FAIL reset_udo got=%h exp=%h", a_udo, 32'h0); end
        checks++; if (a_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", a_ack); end
        checks++; if ({a_valid, a_err, a_retry, a_tout} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {a_valid, a_err, a_retry, a_tout}); end
        checks++; if (a_dbus !== 32'h0) begin failures++; $display("FAIL reset_dbus got=%h exp=0", a_dbus); end
        checks++; if (m_udo !== 32'h0) begin failures++; $display("FAIL reset_m_udo got=%h exp=0", m_udo); end
        rst = 1'b0;
        @(posedge clk); #1;
        xfer(0, Base + 32'h8, 4'hF, 32'h0, 1'b1, 1, rd, ac, na, nv, idb);
        checks++; if (rd !== 32'h0 || na !== 1) begin failures++; $display("FAIL reset_count got=%h acks=%0d exp=0 acks=1", rd, na); end
    endtask

    task automatic test_auto_write();
        xfer(0, Base, 4'b1111, 32'hDEADBEEF, 1'b0, 1, rd, ac, na, nv, idb);
        checks++; if (ac !== 1) begin failures++; $display("FAIL auto_latency got=%0d exp=1", ac); end
        checks++; if (na !== 1) begin failures++; $display("FAIL auto_acks got=%0d exp=1", na); end
        checks++; if (nv !== 1) begin failures++; $display("FAIL auto_valid got=%0d exp=1", nv); end
        checks++; if (a_udo !== 32'hDEADBEEF) begin failures++; $display("FAIL auto_udo got=%h exp=DEADBEEF", a_udo); end
        xfer(0, Base + 32'h8, 4'hF, 32'h0, 1'b1, 1, rd, ac, na, nv, idb);
        checks++; if (rd !== 32'd1) begin failures++; $display("FAIL auto_count got=%h exp=1", rd); end
        checks++; if (idb !== 32'h0) begin failures++; $display("FAIL auto_dbus_idle got=%h exp=0", idb); end
        xfer(0, Base, 4'hF, 32'h0, 1'b1, 1, rd, ac, na, nv, idb);
        checks++; if (rd !== 32'hDEADBEEF || nv !== 0) begin failures++; $display("FAIL auto_data_read got=%h valid=%0d exp=DEADBEEF valid=0", rd, nv); end
    endtask

    task automatic test_byte_enables();
        xfer(0, Base, 4'b0101, 32'h11223344, 1'b0, 1, rd, ac, na, nv, idb);
        checks++; if (a_udo !== 32'hDE22BE44) begin failures++; $display("FAIL be_udo got=%h exp=DE22BE44", a_udo); end
        xfer(0, Base, 4'b0000, 32'hFFFFFFFF, 1'b0, 1, rd, ac, na, nv, idb);
        checks++; if (a_udo !== 32'hDE22BE44 || nv !== 1) begin failures++; $display("FAIL be_zero got=%h valid=%0d exp=DE22BE44 valid=1", a_udo, nv); end
        xfer(0, Base + 32'h8, 4'hF, 32'h0, 1'b1, 1, rd, ac, na, nv, idb);
        checks++; if (rd !== 32'd3) begin failures++; $display("FAIL be_count got=%h exp=3", rd); end
    endtask

    task automatic test_manual_commit();
        xfer(1, Base, 4'hF, 32'h12345678, 1'b0, 1, rd, ac, na, nv, idb);
        checks++; if (m_udo !== 32'h0 || nv !== 0 || na !== 1) begin failures++; $display("FAIL man_hold got=%h valid=%0d acks=%0d exp=0 valid=0 acks=1", m_udo, nv, na); end
        xfer(1, Base + 32'h4, 4'hF, 32'h0, 1'b1, 1, rd, ac, na, nv, idb);
        checks++; if (rd !== 32'd1) begin failures++; $display("FAIL man_pending got=%h exp=1", rd); end
        xfer(1, Base + 32'h4, 4'hF, 32'h7FFFFFFF, 1'b0, 1, rd, ac, na, nv, idb);
        checks++; if (m_udo !== 32'h0 || nv !== 0) begin failures++; $display("FAIL man_ctrl0 got=%h valid=%0d exp=0 valid=0", m_udo, nv); end
        xfer(1, Base + 32'h4, 4'hF, 32'h80000000, 1'b0, 1, rd, ac, na, nv, idb);
        checks++; if (m_udo !== 32'h12345678 || nv !== 1) begin failures++; $display("FAIL man_commit got=%h valid=%0d exp=12345678 valid=1", m_udo, nv); end
        xfer(1, Base + 32'h4, 4'hF, 32'h0, 1'b1, 1, rd, ac, na, nv, idb);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL man_pending_clr got=%h exp=0", rd); end
        xfer(1, Base + 32'h8, 4'hF, 32'h0, 1'b1, 1, rd, ac, na, nv, idb);
        checks++; if (rd !== 32'd1) begin failures++; $display("FAIL man_count got=%h exp=1", rd); end
    endtask

    task automatic test_long_select();
        xfer(0, Base, 4'hF, 32'hAABBCCDD, 1'b0, 6, rd, ac, na, nv, idb);
        checks++; if (na !== 1 || ac !== 1) begin failures++; $display("FAIL long_acks got=%0d at=%0d exp=1 at=1", na, ac); end
        checks++; if (nv !== 1 || a_udo !== 32'hAABBCCDD) begin failures++; $display("FAIL long_commit got=%h valid=%0d exp=AABBCCDD valid=1", a_udo, nv); end
        xfer(0, Base + 32'h8, 4'hF, 32'h5, 1'b0, 1, rd, ac, na, nv, idb);
        checks++; if (na !== 1 || nv !== 0) begin failures++; $display("FAIL count_wr got acks=%0d valid=%0d exp acks=1 valid=0", na, nv); end
        xfer(0, Base + 32'hC, 4'hF, 32'h5, 1'b0, 1, rd, ac, na, nv, idb);
        xfer(0, Base + 32'hC, 4'hF, 32'h0, 1'b1, 1, rd, ac, na, nv, idb);
        checks++; if (rd !== 32'h0 || na !== 1) begin failures++; $display("FAIL reg_c got=%h acks=%0d exp=0 acks=1", rd, na); end
        xfer(0, Base + 32'h8, 4'hF, 32'h0, 1'b1, 1, rd, ac, na, nv, idb);
        checks++; if (rd !== 32'd4) begin failures++; $display("FAIL long_count got=%h exp=4", rd); end
    endtask

    task automatic test_miss();
        xfer(0, 32'h0108B600, 4'hF, 32'h0, 1'b1, 4, rd, ac, na, nv, idb);
        checks++; if (na !== 0 || idb !== 32'h0) begin failures++; $display("FAIL miss_read acks=%0d dbus=%h exp acks=0 dbus=0", na, idb); end
        xfer(0, 32'h0108B4FC, 4'hF, 32'h01010101, 1'b0, 4, rd, ac, na, nv, idb);
        checks++; if (na !== 0 || nv !== 0 || a_udo !== 32'hAABBCCDD) begin failures++; $display("FAIL miss_write acks=%0d valid=%0d udo=%h exp 0 0 AABBCCDD", na, nv, a_udo); end
    endtask

    task automatic test_reset_abort();
        abus = Base; be = 4'hF; dbus = 32'h55555555; rnw = 1'b0; sel_a = 1'b1;
        @(posedge clk); #1;
        checks++; if (a_ack !== 1'b1 || a_udo !== 32'h55555555) begin failures++; $display("FAIL abort_pre ack=%b udo=%h exp 1 55555555", a_ack, a_udo); end
        rst = 1'b1;
        @(posedge clk); #1;
        sel_a = 1'b0;
        checks++; if (a_ack !== 1'b0 || a_valid !== 1'b0) begin failures++; $display("FAIL abort_ack ack=%b valid=%b exp 0 0", a_ack, a_valid); end
        checks++; if (a_udo !== 32'h0) begin failures++; $display("FAIL abort_udo got=%h exp=0", a_udo); end
        rst = 1'b0;
        @(posedge clk); #1;
        xfer(0, Base + 32'h8, 4'hF, 32'h0, 1'b1, 1, rd, ac, na, nv, idb);
        checks++; if (rd !== 32'h0 || na !== 1) begin failures++; $display("FAIL abort_count got=%h acks=%0d exp=0 acks=1", rd, na); end
    endtask

    initial begin
        test_reset();
        test_auto_write();
        test_byte_enables();
        test_manual_commit();
        test_long_select();
        test_miss();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opb_register_ppc2simulink.md
Name: opb_register_ppc2simulink

Overview:
- OPB slave register carrying data from the PowerPC to user fabric; it is the write-side counterpart of the simulink2ppc readback register.
- PPC writes a 32-bit shadow word with byte enables, then commits it to user_data_out, either automatically or through an explicit commit write.
- Issues a one-cycle user_data_valid strobe on each commit and keeps a commit counter for software.
- Single clock domain: user logic consumes the outputs on OPB_Clk.

Parameters:
- C_BASEADDR, 32'h0108B500, first byte address of the 256-byte slave window.
- C_HIGHADDR, 32'h0108B5FF, last byte address of the window.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width.
- C_FAMILY, "virtex6", target family (informational only).
- C_AUTO_COMMIT, 1: 1 = every data write commits; 0 = commit only via the CTRL register.
- C_RESET_VALUE, 32'h00000000, reset value of both shadow and user_data_out.

Ports:
- OPB_Clk  in  1  sole clock.
- OPB_Rst  in  1  synchronous, active-high reset.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7], the most significant byte.
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; zero whenever not acking a read.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- Sl_xferAck  out  1  transfer acknowledge.
- user_data_out  out  [31:0]  committed word; OPB_DBus[0] maps to bit 31.
- user_data_valid  out  1  one-cycle pulse on each commit.

Behaviour:
- Reset (synchronous, OPB_Rst=1 at a rising edge):
  - Sl_xferAck=0, Sl_DBus=0, user_data_valid=0.
  - shadow=user_data_out=C_RESET_VALUE, commit_cnt=0, FSM=IDLE.
  - Reset mid-transfer aborts the transfer: no ack is issued and no write takes effect.
- Address hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- Register offset is OPB_ABus[28:29]:
  - 0x0 DATA: RW shadow.
  - 0x4 CTRL: write bit31 (DBus[0])=1 commits; reads return {31'b0, pending}. pending=1 when shadow != user_data_out bitwise.
  - 0x8 COUNT: RO, commit_cnt[31:0]. Writes are acked and ignored.
  - 0xC: reads 0, writes are acked and ignored.
- FSM has three states: IDLE, ACK, WAIT.
  - IDLE: on a hit, go to ACK. Write side effects happen at this same edge.
  - ACK: Sl_xferAck=1 for exactly this one cycle. For reads, Sl_DBus holds data sampled at the IDLE->ACK edge. Go to WAIT.
  - WAIT: stay until OPB_select=0, then go to IDLE. This guarantees exactly one ack per select assertion.
- Latency: a hit seen in cycle N is acked in cycle N+1.
- DATA write: update only the bytes whose BE bit is set. With BE=0000 the shadow is unchanged; whether a commit still happens follows the commit rules below.
- Commit:
  - user_data_out <= new shadow value, including the bytes just written.
  - user_data_valid=1 in the following cycle (the ACK cycle).
  - commit_cnt increments and wraps from 0xFFFFFFFF to 0.
  - Commit sources: a DATA write when C_AUTO_COMMIT=1; a CTRL write with bit31=1 in either mode.
  - A commit with no data change still pulses valid and still counts.
- CTRL writes with bit31=0 have no effect.
- user_data_out holds its value between commits.
- Reads have no side effects.

Test Plan:
- Reset: hold OPB_Rst for 3 cycles -> user_data_out=0, Sl_xferAck=0, COUNT reads 0.
- Auto-commit write: C_AUTO_COMMIT=1; write 0xDEADBEEF to DATA with BE=1111 ->
  - xferAck exactly 1 cycle after select;
  - user_data_out=32'hDEADBEEF;
  - valid pulses once;
  - COUNT=1.
- Byte enables: from 0xDEADBEEF, write 0x11223344 with BE=0101 -> user_data_out=0xDE22BE44.
- Manual commit: C_AUTO_COMMIT=0.
  - Write 0x12345678 to DATA -> user_data_out unchanged; CTRL reads 1; no valid pulse.
  - Write 0x80000000 to CTRL -> user_data_out=0x12345678, valid pulses, CTRL reads 0.
- Long select: hold select for 6 cycles on a DATA write -> exactly one xferAck and one commit.
- Miss and reset abort:
  - Access 0x0108B600 -> no ack and Sl_DBus=0.
  - Assert reset in the ACK cycle -> ack drops, output returns to C_RESET_VALUE.
